// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: owns PC advance/hold/redirect and the
// decode/execute bubble controls around branches, PC writes and memory waits.
module fetch_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       rst,
  output logic       imemReq,
  input  logic       imemReady,
  input  logic       stallD,
  input  logic       pcWriteD,
  input  logic       pcSrcW,
  input  logic       branchE,
  output logic       pcEnable,
  output logic       pipeEnable,
  output logic       flushD,
  output logic       flushE,
  output logic [2:0] state,
  output logic       timeoutErr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAITMEM = 3'd2,
    S_PCWAIT  = 3'd3
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_err_q, timeout_err_d;
  logic       wait_tick;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    wait_tick     = 1'b0;
    imemReq       = 1'b0;
    pcEnable      = 1'b0;
    pipeEnable    = 1'b0;
    flushD        = 1'b0;
    flushE        = 1'b0;

    case (state_q)
      S_IDLE: begin
        flushD  = 1'b1;
        flushE  = 1'b1;
        state_d = S_FETCH;
      end

      S_FETCH, S_WAITMEM: begin
        imemReq    = 1'b1;
        pipeEnable = 1'b1;
        pcEnable   = imemReady;
        if (branchE) begin
          pcEnable   = 1'b1;
          flushD     = 1'b1;
          flushE     = 1'b1;
          state_d    = S_FETCH;
          wait_cnt_d = 8'd0;
        end else if (stallD) begin
          pcEnable   = 1'b0;
          pipeEnable = 1'b0;
          flushE     = 1'b1;
        end else if (state_q == S_FETCH) begin
          if (pcWriteD) begin
            state_d    = S_PCWAIT;
            wait_cnt_d = 8'd0;
          end else if (!imemReady) begin
            flushD     = 1'b1;
            state_d    = S_WAITMEM;
            wait_cnt_d = 8'd1;
            wait_tick  = 1'b1;
          end else begin
            wait_cnt_d = 8'd0;
          end
        end else begin
          // Memory still outstanding: a stray pcWriteD waits for the word.
          if (!imemReady) begin
            flushD    = 1'b1;
            wait_tick = 1'b1;
            if (wait_cnt_q != 8'hFF) begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end else begin
            state_d    = pcWriteD ? S_PCWAIT : S_FETCH;
            wait_cnt_d = 8'd0;
          end
        end
      end

      S_PCWAIT: begin
        pipeEnable = 1'b1;
        flushD     = 1'b1;
        if (branchE) begin
          pcEnable   = 1'b1;
          flushE     = 1'b1;
          state_d    = S_FETCH;
          wait_cnt_d = 8'd0;
        end else if (stallD) begin
          pipeEnable = 1'b0;
          flushD     = 1'b0;
          flushE     = 1'b1;
        end else if (pcSrcW) begin
          pcEnable = 1'b1;
          state_d  = S_FETCH;
        end
      end

      default: begin
        flushD     = 1'b1;
        flushE     = 1'b1;
        state_d    = S_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase

    if (wait_tick && wait_cnt_d == TIMEOUT) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign state      = state_q;
  assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed test-plan sequences followed by random traffic, all checked
// against a behavioural model of the fetch sequencing rules.
module tb_fetch_ctrl;

  localparam int TO = 4;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       imemReq, imemReady, stallD, pcWriteD, pcSrcW, branchE;
  logic       pcEnable, pipeEnable, flushD, flushE, timeoutErr;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // model: mode 0 idle, 1 fetching, 2 waiting on memory, 3 waiting on PC write
  int m_mode = 0;
  int m_cnt  = 0;
  bit m_err  = 0;

  fetch_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clock      (clock),
    .rst        (rst),
    .imemReq    (imemReq),
    .imemReady  (imemReady),
    .stallD     (stallD),
    .pcWriteD   (pcWriteD),
    .pcSrcW     (pcSrcW),
    .branchE    (branchE),
    .pcEnable   (pcEnable),
    .pipeEnable (pipeEnable),
    .flushD     (flushD),
    .flushE     (flushE),
    .state      (state),
    .timeoutErr (timeoutErr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit st,
                      input bit pw, input bit ps, input bit br);
    bit e_req, e_pc, e_pipe, e_fd, e_fe, mem_wait;
    int n_mode, n_cnt;
    bit n_err;
    rst = r; imemReady = rdy; stallD = st;
    pcWriteD = pw; pcSrcW = ps; branchE = br;
    #1;
    n_mode = m_mode; n_cnt = m_cnt; n_err = m_err;
    e_req = (m_mode == 1 || m_mode == 2);
    if (m_mode == 0) begin
      {e_pc, e_pipe, e_fd, e_fe} = 4'b0011;
      n_mode = 1;
    end else if (br) begin
      {e_pc, e_pipe, e_fd, e_fe} = 4'b1111;
      n_mode = 1; n_cnt = 0;
    end else if (st) begin
      {e_pc, e_pipe, e_fd, e_fe} = 4'b0001;
    end else if (m_mode == 3) begin
      {e_pc, e_pipe, e_fd, e_fe} = {ps, 3'b110};
      n_mode = ps ? 1 : 3;
    end else begin
      mem_wait = !rdy && !(m_mode == 1 && pw);
      {e_pc, e_pipe, e_fd, e_fe} = {rdy, 1'b1, mem_wait, 1'b0};
      if (mem_wait) begin
        n_mode = 2;
        n_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        if (n_cnt == TO) n_err = 1;
      end else begin
        n_mode = pw ? 3 : 1;
        n_cnt = 0;
      end
    end
    check("state", 8'(state), 8'(m_mode));
    check("imemReq", 8'(imemReq), 8'(e_req));
    check("pcEnable", 8'(pcEnable), 8'(e_pc));
    check("pipeEnable", 8'(pipeEnable), 8'(e_pipe));
    check("flushD", 8'(flushD), 8'(e_fd));
    check("flushE", 8'(flushE), 8'(e_fe));
    check("timeoutErr", 8'(timeoutErr), 8'(m_err));
    if (!r) begin
      n_mode = 0; n_cnt = 0; n_err = 0;
    end
    @(posedge clock);
    m_mode = n_mode; m_cnt = n_cnt; m_err = n_err;
    #1;
  endtask

  initial begin
    {imemReady, stallD, pcWriteD, pcSrcW, branchE} = '0;
    @(posedge clock);
    #1;
    // reset held, then release: one idle cycle before fetching
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("first_req", 8'(imemReq), 8'd1);
    // streaming
    repeat (10) step(1, 1, 0, 0, 0, 0);
    // load-use then branch during stall
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1);
    // PC write retiring three cycles later
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    check("pcw_back", 8'(state), 8'd1);
    // memory wait with timeout, then recovery
    repeat (6) step(1, 0, 0, 0, 0, 0);
    check("to_sticky", 8'(timeoutErr), 8'd1);
    step(1, 1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    // branch aborts PCWAIT and WAITMEM
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("to_cleared", 8'(timeoutErr), 8'd0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
